// File: rtl/irq_pkg.sv
// Shared state encoding and constants for the interrupt controller and the main decoder.
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_TAKE = 2'd1,
    IRQ_ISR  = 2'd2
  } irq_state_t;

  localparam logic [31:0] IRQ_VEC_BASE_DEF   = 32'h0000_0100;
  localparam logic [31:0] IRQ_VEC_STRIDE_DEF = 32'h0000_0010;

  // RES (return from interrupt) opcode, also decoded by the main decoder.
  localparam logic [5:0]  IRQ_RES_OPCODE     = 6'b11_1111;

  function automatic logic [31:0] irq_vector(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins; purely combinational.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_IRQ-1:0] i_req,
  output logic             o_vld,
  output logic [ID_W-1:0]  o_idx
);

  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    // Scan high to low so the lowest set index is the last one written.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_vld = 1'b1;
        o_idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Single-level vectored interrupt controller: latches requests, overrides the next PC
// for one cycle to enter the handler, and restores the saved EPC on RES.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          N_IRQ      = 4,
  parameter logic [31:0] VEC_BASE   = IRQ_VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = IRQ_VEC_STRIDE_DEF,
  localparam int         ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic             irq_en,
  input  logic             irq_resume,
  input  logic [31:0]      pc_next_in,
  output logic [31:0]      pc_next_out,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             in_isr,
  output logic [ID_W-1:0]  irq_id,
  output logic [31:0]      epc
);

  irq_state_t       r_state;
  irq_state_t       w_state_nxt;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] w_pending_nxt;
  logic [N_IRQ-1:0] w_clr_mask;
  logic [N_IRQ-1:0] w_id_onehot;
  logic [31:0]      r_epc;
  logic [ID_W-1:0]  r_irq_id;
  logic             w_prio_vld;
  logic [ID_W-1:0]  w_prio_idx;
  logic             w_take_entry;
  logic [31:0]      w_vector;

  irq_prio_enc #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .i_req (r_pending),
    .o_vld (w_prio_vld),
    .o_idx (w_prio_idx)
  );

  assign w_take_entry = (r_state == IRQ_IDLE) && irq_en && w_prio_vld;
  assign w_id_onehot  = N_IRQ'(1) << r_irq_id;
  assign w_vector     = irq_vector(VEC_BASE, VEC_STRIDE, 32'(r_irq_id));

  // A request arriving in the same cycle as its clear keeps the bit set.
  assign w_pending_nxt = (r_pending & ~w_clr_mask) | irq_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IRQ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IRQ_IDLE: if (w_take_entry) w_state_nxt = IRQ_TAKE;
      IRQ_TAKE: w_state_nxt = IRQ_ISR;
      IRQ_ISR:  if (irq_resume) w_state_nxt = IRQ_IDLE;
      default:  w_state_nxt = IRQ_IDLE;
    endcase
  end

  always_comb begin
    pc_next_out = pc_next_in;
    irq_ack     = '0;
    w_clr_mask  = '0;
    in_isr      = 1'b0;
    case (r_state)
      IRQ_TAKE: begin
        pc_next_out = w_vector;
        irq_ack     = w_id_onehot;
        w_clr_mask  = w_id_onehot;
        in_isr      = 1'b1;
      end
      IRQ_ISR: begin
        in_isr = 1'b1;
        // Return is taken the same cycle RES executes: no delay slot.
        if (irq_resume) pc_next_out = r_epc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_epc     <= '0;
      r_irq_id  <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (r_state == IRQ_TAKE) r_epc <= pc_next_in;
      if (w_take_entry) r_irq_id <= w_prio_idx;
    end
  end

  assign irq_id = r_irq_id;
  assign epc    = r_epc;

endmodule
